// File: rtl/alu_md.sv
// MIPS-style ALU with iterative shift-add multiplier and HI/LO registers.
// Define ALU_MD_DIV_EN to add the restoring divider (DIV/DIVU and the DIV state).
module alu_md #(
    parameter int WIDTH = 32,
    parameter int SA_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operando_1,
    input  logic [WIDTH-1:0] operando_2,
    input  logic [SA_W-1:0]  sa,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             zero_signal,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_SLLV  = 6'b000100;
    localparam logic [5:0] OP_SRLV  = 6'b000110;
    localparam logic [5:0] OP_SRAV  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
`ifdef ALU_MD_DIV_EN
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
`endif
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_ADDU  = 6'b100001;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_SUBU  = 6'b100011;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLTU  = 6'b101011;
    localparam logic [5:0] OP_INV   = 6'b111111;

    localparam logic [WIDTH-1:0] IMM_MASK = WIDTH'(64'h0000_0000_0000_FFFF);
    localparam logic [SA_W-1:0]  LAST     = SA_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1
`ifdef ALU_MD_DIV_EN
        , S_DIV = 2'd2
`endif
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     result_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 out_valid_q;
    logic [2*WIDTH-1:0]   p_q;
    logic [WIDTH-1:0]     m_q;
    logic [SA_W-1:0]      cnt_q;
    logic                 neg_lo_q;

    logic [5:0]           eff_op_s;
    logic                 sgn_s;
    logic [WIDTH-1:0]     a_abs_s;
    logic [WIDTH-1:0]     b_abs_s;
    logic [WIDTH-1:0]     imm_z_s;
    logic [WIDTH-1:0]     alu_res_s;
    logic                 start_mul_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [2*WIDTH-1:0]   mul_fin_s;

    // Operation class to effective opcode, plus operand magnitudes for signed mul/div
    always_comb begin
        case (ALUOp)
            2'b00:   eff_op_s = OP_ADD;
            2'b01:   eff_op_s = OP_SUB;
            2'b10:   eff_op_s = operation;
            default: eff_op_s = OP_INV;
        endcase
        // MULT/DIV have bit 0 clear, MULTU/DIVU have it set
        sgn_s       = ~eff_op_s[0];
        a_abs_s     = (sgn_s && operando_1[WIDTH-1]) ? -operando_1 : operando_1;
        b_abs_s     = (sgn_s && operando_2[WIDTH-1]) ? -operando_2 : operando_2;
        imm_z_s     = operando_2 & IMM_MASK;
        start_mul_s = (eff_op_s == OP_MULT) || (eff_op_s == OP_MULTU);
    end

    // Single-cycle result; anything not listed yields all ones
    always_comb begin
        alu_res_s = '1;
        case (eff_op_s)
            OP_SLL:                           alu_res_s = operando_2 << sa;
            OP_SRL:                           alu_res_s = operando_2 >> sa;
            OP_SRA:                           alu_res_s = $signed(operando_2) >>> sa;
            OP_SLLV:                          alu_res_s = operando_2 << operando_1[SA_W-1:0];
            OP_SRLV:                          alu_res_s = operando_2 >> operando_1[SA_W-1:0];
            OP_SRAV:                          alu_res_s = $signed(operando_2) >>> operando_1[SA_W-1:0];
            OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: alu_res_s = operando_1 + operando_2;
            OP_SUB, OP_SUBU:                  alu_res_s = operando_1 - operando_2;
            OP_AND:                           alu_res_s = operando_1 & operando_2;
            OP_OR:                            alu_res_s = operando_1 | operando_2;
            OP_XOR:                           alu_res_s = operando_1 ^ operando_2;
            OP_NOR:                           alu_res_s = ~(operando_1 | operando_2);
            OP_SLT, OP_SLTI:                  alu_res_s = WIDTH'($signed(operando_1) < $signed(operando_2));
            OP_SLTU, OP_SLTIU:                alu_res_s = WIDTH'(operando_1 < operando_2);
            OP_ANDI:                          alu_res_s = operando_1 & imm_z_s;
            OP_ORI:                           alu_res_s = operando_1 | imm_z_s;
            OP_XORI:                          alu_res_s = operando_1 ^ imm_z_s;
            OP_LUI:                           alu_res_s = imm_z_s << 6'd16;
            OP_MFHI:                          alu_res_s = hi_q;
            OP_MFLO:                          alu_res_s = lo_q;
            OP_MTHI, OP_MTLO:                 alu_res_s = operando_1;
            default:                          alu_res_s = '1;
        endcase
    end

    // One shift-add step: upper half accumulates multiplicand, whole product shifts right
    always_comb begin
        mul_sum_s  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, p_q[WIDTH-1:1]};
        mul_fin_s  = neg_lo_q ? -mul_next_s : mul_next_s;
    end

`ifdef ALU_MD_DIV_EN
    logic                 neg_hi_q;
    logic                 dz_q;
    logic [WIDTH-1:0]     a_q;
    logic                 start_div_s;
    logic [WIDTH:0]       div_sh_s;
    logic [WIDTH:0]       div_diff_s;
    logic [2*WIDTH-1:0]   div_next_s;
    logic [WIDTH-1:0]     div_lo_s;
    logic [WIDTH-1:0]     div_hi_s;

    // One restoring-division step on {remainder, dividend}, then sign and divide-by-zero fix-up
    always_comb begin
        start_div_s = (eff_op_s == OP_DIV) || (eff_op_s == OP_DIVU);
        div_sh_s    = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_diff_s  = div_sh_s - {1'b0, m_q};
        if (!div_diff_s[WIDTH]) begin
            div_next_s = {div_diff_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {div_sh_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        end
        if (dz_q) begin
            div_lo_s = neg_hi_q ? WIDTH'(1'b1) : '1;
            div_hi_s = a_q;
        end else begin
            div_lo_s = neg_lo_q ? -div_next_s[WIDTH-1:0] : div_next_s[WIDTH-1:0];
            div_hi_s = neg_hi_q ? -div_next_s[2*WIDTH-1:WIDTH] : div_next_s[2*WIDTH-1:WIDTH];
        end
    end
`endif

    // Control FSM with HI/LO, result and iteration datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            neg_lo_q    <= 1'b0;
`ifdef ALU_MD_DIV_EN
            neg_hi_q    <= 1'b0;
            dz_q        <= 1'b0;
            a_q         <= '0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (start_mul_s) begin
                            state_q  <= S_MUL;
                            p_q      <= {{WIDTH{1'b0}}, b_abs_s};
                            m_q      <= a_abs_s;
                            cnt_q    <= '0;
                            neg_lo_q <= sgn_s & (operando_1[WIDTH-1] ^ operando_2[WIDTH-1]);
                        end
`ifdef ALU_MD_DIV_EN
                        else if (start_div_s) begin
                            state_q  <= S_DIV;
                            p_q      <= {{WIDTH{1'b0}}, a_abs_s};
                            m_q      <= b_abs_s;
                            cnt_q    <= '0;
                            neg_lo_q <= sgn_s & (operando_1[WIDTH-1] ^ operando_2[WIDTH-1]);
                            neg_hi_q <= sgn_s & operando_1[WIDTH-1];
                            dz_q     <= (operando_2 == '0);
                            a_q      <= operando_1;
                        end
`endif
                        else begin
                            result_q    <= alu_res_s;
                            out_valid_q <= 1'b1;
                            if (eff_op_s == OP_MTHI) begin
                                hi_q <= operando_1;
                            end
                            if (eff_op_s == OP_MTLO) begin
                                lo_q <= operando_1;
                            end
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == LAST) begin
                        state_q     <= S_IDLE;
                        hi_q        <= mul_fin_s[2*WIDTH-1:WIDTH];
                        lo_q        <= mul_fin_s[WIDTH-1:0];
                        result_q    <= mul_fin_s[WIDTH-1:0];
                        out_valid_q <= 1'b1;
                    end else begin
                        p_q   <= mul_next_s;
                        cnt_q <= cnt_q + SA_W'(1'b1);
                    end
                end
`ifdef ALU_MD_DIV_EN
                S_DIV: begin
                    if (cnt_q == LAST) begin
                        state_q     <= S_IDLE;
                        hi_q        <= div_hi_s;
                        lo_q        <= div_lo_s;
                        result_q    <= div_lo_s;
                        out_valid_q <= 1'b1;
                    end else begin
                        p_q   <= div_next_s;
                        cnt_q <= cnt_q + SA_W'(1'b1);
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign result      = result_q;
    assign out_valid   = out_valid_q;
    assign zero_signal = (result_q == '0);

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md (WIDTH=32): behavioural model compared every cycle
// plus directed vectors with hand-computed results.
module tb_alu_md;

    typedef struct packed {
        logic        multi;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
    } mres_t;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] opa      = 32'd0;
    logic [31:0] opb      = 32'd0;
    logic [4:0]  sa_v     = 5'd0;
    logic [1:0]  aluop    = 2'd0;
    logic [5:0]  funct    = 6'd0;
    logic        in_ready;
    logic        busy;
    logic        out_valid;
    logic        zero_signal;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    alu_md #(.WIDTH(32), .SA_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operando_1 (opa),
        .operando_2 (opb),
        .sa         (sa_v),
        .ALUOp      (aluop),
        .operation  (funct),
        .result     (result),
        .zero_signal(zero_signal),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Architectural effect of one accepted request, from the instruction semantics
    function automatic mres_t model_op(input logic [1:0] c, input logic [5:0] fn,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] s, input logic [31:0] hi,
                                       input logic [31:0] lo);
        mres_t r;
        logic [5:0] e;
        logic [63:0] p;
        logic signed [31:0] as32;
        logic signed [31:0] bs32;
        r.multi = 1'b0; r.res = 32'hFFFF_FFFF; r.hi = hi; r.lo = lo;
        as32 = a; bs32 = b;
        e = (c == 2'b00) ? 6'h20 : (c == 2'b01) ? 6'h22 : (c == 2'b10) ? fn : 6'h3F;
        case (e)
            6'h00: r.res = b << s;
            6'h02: r.res = b >> s;
            6'h03: r.res = 32'(bs32 >>> s);
            6'h04: r.res = b << a[4:0];
            6'h06: r.res = b >> a[4:0];
            6'h07: r.res = 32'(bs32 >>> a[4:0]);
            6'h20, 6'h21, 6'h08, 6'h09: r.res = a + b;
            6'h22, 6'h23: r.res = a - b;
            6'h24: r.res = a & b;
            6'h25: r.res = a | b;
            6'h26: r.res = a ^ b;
            6'h27: r.res = ~(a | b);
            6'h2A, 6'h0A: r.res = (as32 < bs32) ? 32'd1 : 32'd0;
            6'h2B, 6'h0B: r.res = (a < b) ? 32'd1 : 32'd0;
            6'h0C: r.res = a & {16'd0, b[15:0]};
            6'h0D: r.res = a | {16'd0, b[15:0]};
            6'h0E: r.res = a ^ {16'd0, b[15:0]};
            6'h0F: r.res = {b[15:0], 16'd0};
            6'h10: r.res = hi;
            6'h12: r.res = lo;
            6'h11: begin r.res = a; r.hi = a; end
            6'h13: begin r.res = a; r.lo = a; end
            6'h18: begin
                p = 64'(longint'(as32) * longint'(bs32));
                r.multi = 1'b1; r.hi = p[63:32]; r.lo = p[31:0];
            end
            6'h19: begin
                p = {32'd0, a} * {32'd0, b};
                r.multi = 1'b1; r.hi = p[63:32]; r.lo = p[31:0];
            end
`ifdef ALU_MD_DIV_EN
            6'h1A: begin
                r.multi = 1'b1;
                if (b == 32'd0) begin
                    r.lo = (as32 < 0) ? 32'd1 : 32'hFFFF_FFFF; r.hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.lo = a; r.hi = 32'd0;
                end else begin
                    r.lo = 32'(as32 / bs32); r.hi = 32'(as32 % bs32);
                end
            end
            6'h1B: begin
                r.multi = 1'b1;
                if (b == 32'd0) begin
                    r.lo = 32'hFFFF_FFFF; r.hi = a;
                end else begin
                    r.lo = a / b; r.hi = a % b;
                end
            end
`endif
            default: r.res = 32'hFFFF_FFFF;
        endcase
        return r;
    endfunction

    mres_t       mo;
    logic        m_busy  = 1'b0;
    logic        m_valid = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_res   = 32'd0;
    logic [31:0] m_hi    = 32'd0;
    logic [31:0] m_lo    = 32'd0;
    logic [31:0] p_hi    = 32'd0;
    logic [31:0] p_lo    = 32'd0;

    assign mo = model_op(aluop, funct, opa, opb, sa_v, m_hi, m_lo);

    // Reference timing: one cycle for simple ops, 32 busy cycles for multi-cycle ops
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
            m_res <= 32'd0; m_hi <= 32'd0; m_lo <= 32'd0;
        end else begin
            m_valid <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0; m_valid <= 1'b1;
                    m_res <= p_lo; m_hi <= p_hi; m_lo <= p_lo;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (in_valid) begin
                if (mo.multi) begin
                    m_busy <= 1'b1; m_cnt <= 32; p_hi <= mo.hi; p_lo <= mo.lo;
                end else begin
                    m_valid <= 1'b1; m_res <= mo.res; m_hi <= mo.hi; m_lo <= mo.lo;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("busy", 32'(busy), 32'(m_busy));
        check("in_ready", 32'(in_ready), 32'(!m_busy));
        check("result", result, m_res);
        check("zero_signal", 32'(zero_signal), 32'(m_res == 32'd0));
    end

    task automatic issue(input logic [1:0] c, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
        @(negedge clk);
        aluop = c; funct = f; opa = a; opb = b; sa_v = s; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, " out_valid seen"}, 32'(out_valid), 32'd1);
    endtask

    task automatic op_lit(input string name, input logic [1:0] c, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] s,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        issue(c, f, a, b, s);
        wait_valid(name, lat);
        check(name, result, exp_res);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int lat;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset result", result, 32'd0);
        check("reset zero_signal", 32'(zero_signal), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 32'(in_ready), 32'd1);

        op_lit("add_wrap", 2'b00, 6'h00, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 0);
        check("add_wrap zero_signal", 32'(zero_signal), 32'd1);
        op_lit("sub", 2'b01, 6'h00, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 0);
        op_lit("sll", 2'b10, 6'h00, 32'd0, 32'h0000_00F1, 5'd4, 32'h0000_0F10, 0);
        op_lit("sra", 2'b10, 6'h03, 32'd0, 32'h8000_0010, 5'd4, 32'hF800_0001, 0);
        op_lit("srlv", 2'b10, 6'h06, 32'h0000_0023, 32'h8000_0000, 5'd0, 32'h1000_0000, 0);
        op_lit("slt", 2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 0);
        op_lit("sltu", 2'b10, 6'h2B, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 0);
        op_lit("nor", 2'b10, 6'h27, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 32'h0F0F_F0F0, 0);
        op_lit("andi", 2'b10, 6'h0C, 32'hFFFF_FFFF, 32'hABCD_1234, 5'd0, 32'h0000_1234, 0);
        op_lit("lui", 2'b10, 6'h0F, 32'd0, 32'hFFFF_1234, 5'd0, 32'h1234_0000, 0);
        op_lit("aluop_11", 2'b11, 6'h20, 32'd1, 32'd2, 5'd0, 32'hFFFF_FFFF, 0);
        op_lit("unlisted", 2'b10, 6'h3E, 32'd1, 32'd2, 5'd0, 32'hFFFF_FFFF, 0);
        op_lit("mthi", 2'b10, 6'h11, 32'hCAFE_0001, 32'd0, 5'd0, 32'hCAFE_0001, 0);
        op_lit("mfhi_after_mthi", 2'b10, 6'h10, 32'd0, 32'd0, 5'd0, 32'hCAFE_0001, 0);

        op_lit("mult", 2'b10, 6'h18, 32'hFFFF_FFFD, 32'd7, 5'd0, 32'hFFFF_FFEB, 32);
        op_lit("mfhi_mult", 2'b10, 6'h10, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 0);
        op_lit("mflo_mult", 2'b10, 6'h12, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFEB, 0);
        op_lit("multu_max", 2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd1, 32);
        op_lit("mfhi_multu", 2'b10, 6'h10, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFE, 0);

`ifdef ALU_MD_DIV_EN
        op_lit("div", 2'b10, 6'h1A, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'hFFFF_FFFD, 32);
        op_lit("mfhi_div", 2'b10, 6'h10, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 0);
        op_lit("divu_zero", 2'b10, 6'h1B, 32'h1234_5678, 32'd0, 5'd0, 32'hFFFF_FFFF, 32);
        op_lit("mfhi_divu_zero", 2'b10, 6'h10, 32'd0, 32'd0, 5'd0, 32'h1234_5678, 0);
        op_lit("div_most_neg", 2'b10, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000, 32);
        op_lit("mfhi_most_neg", 2'b10, 6'h10, 32'd0, 32'd0, 5'd0, 32'd0, 0);
        op_lit("div_zero_neg", 2'b10, 6'h1A, 32'hFFFF_FFF0, 32'd0, 5'd0, 32'd1, 32);
        op_lit("divu", 2'b10, 6'h1B, 32'd256, 32'd7, 5'd0, 32'd36, 32);
        op_lit("mfhi_divu", 2'b10, 6'h10, 32'd0, 32'd0, 5'd0, 32'd4, 0);
`else
        op_lit("mtlo", 2'b10, 6'h13, 32'h0000_0055, 32'd0, 5'd0, 32'h0000_0055, 0);
        op_lit("div_disabled", 2'b10, 6'h1A, 32'd7, 32'd2, 5'd0, 32'hFFFF_FFFF, 0);
        op_lit("divu_disabled", 2'b10, 6'h1B, 32'd7, 32'd0, 5'd0, 32'hFFFF_FFFF, 0);
        op_lit("mflo_unchanged", 2'b10, 6'h12, 32'd0, 32'd0, 5'd0, 32'h0000_0055, 0);
`endif

        // in_valid held high across a multiply; SRAV queued behind it
        @(negedge clk);
        aluop = 2'b10; funct = 6'h19; opa = 32'd3; opb = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        wait_valid("multu_hold", lat);
        check("multu_hold", result, 32'd15);
        check("multu_hold latency", 32'(lat), 32'd32);
        funct = 6'h07; opa = 32'h0000_0024; opb = 32'h8000_0000;
        @(negedge clk);
        in_valid = 1'b0;
        check("srav_after_hold valid", 32'(out_valid), 32'd1);
        check("srav_after_hold", result, 32'hF800_0000);

        // reset in the middle of a multi-cycle operation
`ifdef ALU_MD_DIV_EN
        issue(2'b10, 6'h1A, 32'd100, 32'd3, 5'd0);
`else
        issue(2'b10, 6'h18, 32'd100, 32'd3, 5'd0);
`endif
        lat = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        check("abort no early out_valid", 32'(lat), 32'd0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("abort busy cleared", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort no out_valid", 32'(out_valid), 32'd0);
        op_lit("mfhi_after_abort", 2'b10, 6'h10, 32'd0, 32'd0, 5'd0, 32'd0, 0);
        op_lit("mflo_after_abort", 2'b10, 6'h12, 32'd0, 32'd0, 5'd0, 32'd0, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL take parameter WIDTH, default 32, datapath width in bits (legal 8..64, power of two).
REQ-002 SHALL take parameter SA_W, default 5, shift-amount width, equal to log2(WIDTH).
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operation request.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have ports operando_1 and operando_2, input, WIDTH, operands A and B.
REQ-008 SHALL have port sa, input, SA_W, immediate shift amount.
REQ-009 SHALL have port ALUOp, input, 2, operation class.
REQ-010 SHALL have port operation, input, 6, MIPS funct/opcode select.
REQ-011 SHALL have port result, output, WIDTH, registered result.
REQ-012 SHALL have port zero_signal, output, 1, high when result equals 0.
REQ-013 SHALL have port out_valid, output, 1, one-cycle pulse marking a new result.
REQ-014 SHALL have port busy, output, 1, multi-cycle operation in progress.

Function
REQ-015 Effective op SHALL be: ALUOp 00 -> ADD (100000), 01 -> SUB (100010), 10 -> operation, 11 -> invalid.
REQ-016 Request accepted on a rising edge where in_valid and in_ready are both high; in_ready SHALL equal state IDLE.
REQ-017 Single-cycle ops (SLL, SRL, SRA, SLLV, SRLV, SRAV, ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, ADDI, ADDIU, ANDI, ORI, XORI, LUI, SLTI, SLTIU; existing 6-bit codes) SHALL register result on the accepting edge with out_valid high for the following cycle.
REQ-018 Variable shifts SHALL use operando_1[SA_W-1:0] only; immediate shifts use sa; shifts SHALL be true shifts, not multiply or divide.
REQ-019 Immediate logic ops SHALL zero-extend operando_2[15:0]; LUI SHALL produce operando_2[15:0] followed by 16 zeros, truncated to WIDTH.
REQ-020 Add and sub SHALL wrap modulo 2^WIDTH with no overflow trap.
REQ-021 Invalid or unlisted op SHALL load result with all ones and pulse out_valid.
REQ-022 SHALL hold internal HI and LO registers, each WIDTH bits wide.
REQ-023 MFHI (010000) and MFLO (010010) SHALL load result from HI or LO in one cycle; MTHI (010001) and MTLO (010011) SHALL write operando_1 to HI or LO and load result with operando_1.
REQ-024 MULT (011000) and MULTU (011001) SHALL compute the 2*WIDTH-bit signed or unsigned product by iterative shift-add, HI = upper half, LO = lower half.
REQ-025 DIV (011010) and DIVU (011011) SHALL compute by restoring division: LO = quotient, HI = remainder; signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-026 FSM states SHALL be IDLE, MUL, DIV; a MULT or DIV accept moves IDLE to MUL or DIV; exactly WIDTH cycles later HI and LO update, result loads LO, out_valid pulses, and the FSM returns to IDLE.
REQ-027 busy SHALL be high in MUL and DIV; in_valid SHALL be ignored while busy.
REQ-028 Divide by zero SHALL take WIDTH cycles and give LO = all ones and HI = dividend (DIVU); for DIV, LO = all ones if the dividend is non-negative, else 1.
REQ-029 DIV with the most-negative dividend and divisor -1 SHALL give LO = most-negative and HI = 0.
REQ-030 zero_signal SHALL be combinationally derived from the registered result.
REQ-031 result SHALL hold its value between out_valid pulses.

Reset
REQ-032 While rst_n is low, the FSM SHALL be IDLE and result, HI, LO, out_valid and busy SHALL be 0; zero_signal is therefore 1.
REQ-033 Reset asserted mid multiply or divide SHALL abort it with no out_valid and no HI/LO update.
REQ-034 in_ready SHALL be high in the first cycle after rst_n deasserts.

Configuration
REQ-035 Macro ALU_MD_DIV_EN defined SHALL include DIV, DIVU and the DIV state.
REQ-036 Without ALU_MD_DIV_EN, DIV and DIVU SHALL be single-cycle invalid ops: result all ones, out_valid pulsed, HI and LO unchanged, busy never set.

Verification (WIDTH=32 unless noted)
REQ-037 ADD with A=0xFFFFFFFF, B=1 -> result 0, zero_signal 1, out_valid one cycle after accept.
REQ-038 MULT with A=-3, B=7, then MFHI and MFLO -> busy for 32 cycles, out_valid at cycle 32, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-039 DIV with A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with B=0 -> LO=0xFFFFFFFF, HI=A.
REQ-040 in_valid held high during MULTU -> second request accepted only in the cycle after out_valid; SRAV with A=0x24, B=0x80000000 -> 0xF8000000.
REQ-041 rst_n pulsed low at cycle 10 of a DIV -> no out_valid, HI=LO=0, in_ready high after release.
REQ-042 WIDTH=16 build without ALU_MD_DIV_EN: DIVU -> result 0xFFFF in one cycle, MULTU 0xFFFF*0xFFFF -> HI=0xFFFE, LO=0x0001 after 16 cycles.
